vector_memory_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the vector MEMORY block. Shares the single MEMORY port between

---
 rtl/vector_memory_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vector_memory_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_memory_arbiter.sv
// Round-robin arbiter/sequencer sharing the single vector MEMORY port between the core
// pipeline (requester 0) and the data loader (requester 1); runs bursts and tags read returns.
module vector_memory_arbiter #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [31:0]      addr0,
  input  logic [31:0]      addr1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic             we0,
  input  logic             we1,
  input  logic             e0,
  input  logic             e1,
  input  logic             s0,
  input  logic             s1,
  input  logic [1:0]       pos0,
  input  logic [1:0]       pos1,
  input  logic [31:0]      wdv0,
  input  logic [31:0]      wdv1,
  input  logic [31:0]      wds0,
  input  logic [31:0]      wds1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [31:0]      rdata,
  output logic             busy,
  output logic [31:0]      m_a,
  output logic [31:0]      m_wdv,
  output logic [31:0]      m_wds,
  output logic [1:0]       m_pos,
  output logic             m_we,
  output logic             m_e,
  output logic             m_s,
  input  logic [31:0]      m_rd
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      base_q, base_d;
  logic             we_q, we_d;
  logic             e_q, e_d;
  logic             s_q, s_d;
  logic [1:0]       pos_q, pos_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             winner;

  // On a tie the requester that did not win last time gets the port.
  assign winner = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      count_q   <= '0;
      len_q     <= '0;
      base_q    <= '0;
      we_q      <= 1'b0;
      e_q       <= 1'b0;
      s_q       <= 1'b0;
      pos_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      count_q   <= count_d;
      len_q     <= len_d;
      base_q    <= base_d;
      we_q      <= we_d;
      e_q       <= e_d;
      s_q       <= s_d;
      pos_q     <= pos_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    len_d   = len_q;
    base_d  = base_q;
    we_d    = we_q;
    e_d     = e_q;
    s_d     = s_q;
    pos_d   = pos_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StBusy;
          owner_d = winner;
          last_d  = winner;
          count_d = '0;
          base_d  = winner ? addr1 : addr0;
          len_d   = winner ? len1  : len0;
          we_d    = winner ? we1   : we0;
          e_d     = winner ? e1    : e0;
          s_d     = winner ? s1    : s0;
          pos_d   = winner ? pos1  : pos0;
        end
      end
      StBusy: begin
        count_d = count_q + 1'b1;
        if (count_q == len_q) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read data arrives one cycle after the beat; the strobe carries the issuing owner's tag.
  always_comb begin
    rvalid0_d = (state_q == StBusy) && !we_q && !owner_q;
    rvalid1_d = (state_q == StBusy) && !we_q && owner_q;
  end

  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    ack0  = 1'b0;
    ack1  = 1'b0;
    busy  = 1'b0;
    m_a   = '0;
    m_wdv = '0;
    m_wds = '0;
    m_pos = '0;
    m_we  = 1'b0;
    m_e   = 1'b0;
    m_s   = 1'b0;
    if (state_q == StBusy) begin
      gnt0  = ~owner_q;
      gnt1  = owner_q;
      ack0  = ~owner_q;
      ack1  = owner_q;
      busy  = 1'b1;
      m_a   = base_q + 32'(count_q);
      m_wdv = owner_q ? wdv1 : wdv0;
      m_wds = owner_q ? wds1 : wds0;
      m_pos = pos_q;
      m_we  = we_q;
      m_e   = e_q;
      m_s   = s_q;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = m_rd;

endmodule

// File: tb/tb_vector_memory_arbiter.sv
// Bench for vector_memory_arbiter: a burst-level reference model plus a MEMORY model,
// checked every cycle, with directed scenarios pinned by literal expectations.
module tb_vector_memory_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        req [2];
  logic [31:0] addr [2];
  logic [3:0]  len [2];
  logic        we [2];
  logic        e [2];
  logic        s [2];
  logic [1:0]  pos [2];
  logic [31:0] wdv [2];
  logic [31:0] wds [2];
  logic gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, busy, m_we, m_e, m_s;
  logic [31:0] rdata, m_a, m_wdv, m_wds, m_rd;
  logic [1:0]  m_pos;

  int errors = 0;
  int checks = 0;

  vector_memory_arbiter #(.LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .req1(req[1]), .addr0(addr[0]), .addr1(addr[1]),
    .len0(len[0]), .len1(len[1]), .we0(we[0]), .we1(we[1]),
    .e0(e[0]), .e1(e[1]), .s0(s[0]), .s1(s[1]), .pos0(pos[0]), .pos1(pos[1]),
    .wdv0(wdv[0]), .wdv1(wdv[1]), .wds0(wds[0]), .wds1(wds[1]),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .busy(busy),
    .m_a(m_a), .m_wdv(m_wdv), .m_wds(m_wds), .m_pos(m_pos),
    .m_we(m_we), .m_e(m_e), .m_s(m_s), .m_rd(m_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // MEMORY model: synchronous write, registered read; element writes replace byte POS with WDS.
  bit [31:0] mem [bit [31:0]];
  initial begin
    bit [31:0] rd_next;
    bit [31:0] w;
    m_rd = '0;
    forever begin
      @(posedge clk);
      rd_next = mem.exists(m_a) ? mem[m_a] : 32'h0;
      if (m_we) begin
        w = rd_next;
        if (m_e) w[m_pos*8 +: 8] = m_wds[7:0];
        else     w = m_wdv;
        mem[m_a] = w;
      end
      m_rd = rd_next;
    end
  end

  // Reference model: whole-burst view (owner, cursor, beats left) and a queue of read returns.
  bit [31:0]   gold [bit [31:0]];
  logic [31:0] rq [$];
  logic        mb = 1'b0, mo = 1'b0, ml = 1'b1;
  logic        mwe = 1'b0, me = 1'b0, ms = 1'b0;
  logic [1:0]  mpos = '0;
  logic [31:0] maddr = '0;
  int          mleft = 0;
  logic        erv0 = 1'b0, erv1 = 1'b0;

  initial begin
    bit [31:0] w;
    logic win;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mb = 1'b0; mo = 1'b0; ml = 1'b1; erv0 = 1'b0; erv1 = 1'b0;
        rq.delete();
      end else begin
        erv0 = 1'b0;
        erv1 = 1'b0;
        if (mb) begin
          w = gold.exists(maddr) ? gold[maddr] : 32'h0;
          if (mwe) begin
            if (me) w[mpos*8 +: 8] = wds[mo][7:0];
            else    w = wdv[mo];
            gold[maddr] = w;
          end else begin
            rq.push_back(w);
            if (mo) erv1 = 1'b1;
            else    erv0 = 1'b1;
          end
          maddr = maddr + 32'd1;
          mleft--;
          if (mleft == 0) mb = 1'b0;
        end else if (req[0] || req[1]) begin
          win   = (req[0] && req[1]) ? !ml : req[1];
          mb    = 1'b1;
          mo    = win;
          ml    = win;
          maddr = addr[win];
          mleft = int'(len[win]) + 1;
          mwe   = we[win];
          me    = e[win];
          ms    = s[win];
          mpos  = pos[win];
        end
      end
    end
  end

  // Logs for the directed scenarios.
  logic [31:0] log_a [$];
  logic [31:0] log_rd [$];
  logic        log_busy [$];
  logic        log_own [$];
  logic        prev_busy = 1'b0;

  task automatic clear_logs();
    log_a.delete(); log_rd.delete(); log_busy.delete(); log_own.delete();
  endtask

  initial begin
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      chk("busy", busy, mb);
      chk("gnt0", gnt0, mb && !mo);
      chk("gnt1", gnt1, mb && mo);
      chk("ack0", ack0, mb && !mo);
      chk("ack1", ack1, mb && mo);
      chk("m_we", m_we, mb && mwe);
      chk("m_e", m_e, mb && me);
      chk("m_s", m_s, mb && ms);
      chk("rvalid0", rvalid0, erv0);
      chk("rvalid1", rvalid1, erv1);
      if (mb) begin
        chk("m_a", m_a, maddr);
        chk("m_pos", m_pos, mpos);
        chk("m_wdv", m_wdv, wdv[mo]);
        chk("m_wds", m_wds, wds[mo]);
        log_a.push_back(m_a);
      end
      if (erv0 || erv1) begin
        if (rq.size() == 0) begin
          chk("read_queue_empty", 32'd0, 32'd1);
        end else begin
          exp_rd = rq.pop_front();
          chk("rdata", rdata, exp_rd);
        end
      end
      if (rvalid0 || rvalid1) log_rd.push_back(rdata);
      if ((gnt0 || gnt1) && !prev_busy) log_own.push_back(gnt1);
      log_busy.push_back(busy);
      prev_busy = busy;
    end
  end

  // Drives one burst from requester n; entered and left at posedge+1.
  task automatic burst(input int n, input logic [31:0] a, input int ln, input logic w,
                       input logic el, input logic [1:0] p, input logic [31:0] d0,
                       input logic [31:0] step);
    int t;
    logic granted;
    req[n] = 1'b1; addr[n] = a; len[n] = ln[3:0]; we[n] = w; e[n] = el; s[n] = 1'b0;
    pos[n] = p; wdv[n] = d0; wds[n] = d0;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
      granted = (n == 1) ? gnt1 : gnt0;
    end while (!granted && t < 40);
    chk("grant_seen", granted, 1'b1);
    req[n] = 1'b0;
    if (granted) begin
      for (int k = 0; k <= ln; k++) begin
        wdv[n] = d0 + k * step;
        wds[n] = d0 + k * step;
        @(posedge clk); #1;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] pat;
    int cnt;
    int t;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; addr[i] = 0; len[i] = 0; we[i] = 0; e[i] = 0; s[i] = 0; pos[i] = 0;
      wdv[i] = 0; wds[i] = 0;
    end
    #12;
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rvalid0", rvalid0, 1'b0);
    chk("rst_m_a", m_a, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-beat write.
    clear_logs();
    burst(0, 32'd5, 0, 1'b1, 1'b0, 2'd0, 32'd32, 32'd0);
    chk("w1_beats", log_a.size(), 1);
    chk("w1_addr", log_a[0], 32'd5);
    chk("w1_busy_after", busy, 1'b0);

    // Fill 5..8 then a 4-beat read by requester 1.
    burst(0, 32'd5, 3, 1'b1, 1'b0, 2'd0, 32'd50, 32'd10);
    clear_logs();
    burst(1, 32'd5, 3, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("rd4_beats", log_a.size(), 4);
    chk("rd4_rvalid_cnt", log_rd.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rd4_addr", log_a[i], 32'd5 + i);
      chk("rd4_data", log_rd[i], 32'd50 + 10 * i);
    end

    // Address wrap.
    clear_logs();
    burst(0, 32'hFFFF_FFFE, 3, 1'b1, 1'b0, 2'd0, 32'd1, 32'd1);
    chk("wrap_a0", log_a[0], 32'hFFFF_FFFE);
    chk("wrap_a1", log_a[1], 32'hFFFF_FFFF);
    chk("wrap_a2", log_a[2], 32'h0000_0000);
    chk("wrap_a3", log_a[3], 32'h0000_0001);

    // Element write of byte 3.
    burst(0, 32'd1, 0, 1'b1, 1'b0, 2'd0, 32'h0302_0100, 32'd0);
    burst(0, 32'd1, 0, 1'b1, 1'b1, 2'd3, 32'h0000_000A, 32'd0);
    clear_logs();
    burst(0, 32'd1, 0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk("elem_cnt", log_rd.size(), 1);
    chk("elem_data", log_rd[0], 32'h0A02_0100);

    // Tie from reset: grants alternate 0,1,0,1 with one idle bubble.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b1; len[i] = 4'd1; we[i] = 1'b0; e[i] = 1'b0; addr[i] = 32'd5 + 2 * i;
    end
    clear_logs();
    repeat (12) @(posedge clk);
    #1;
    req[0] = 1'b0;
    req[1] = 1'b0;
    pat = 12'b0110_1101_1011;
    chk("tie_len", log_busy.size(), 12);
    for (int i = 0; i < 12; i++) chk("tie_busy", log_busy[i], pat[11-i]);
    chk("tie_grants", log_own.size(), 4);
    for (int i = 0; i < 4; i++) chk("tie_owner", log_own[i], i % 2);
    repeat (4) @(posedge clk);
    #1;

    // Reset during the second beat of an 8-beat read.
    req[0] = 1'b1; addr[0] = 32'd5; len[0] = 4'd7; we[0] = 1'b0; e[0] = 1'b0;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!gnt0 && t < 40);
    chk("mid_grant", gnt0, 1'b1);
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid_rvalid_before", rvalid0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_gnt0", gnt0, 1'b0);
    chk("mid_ack0", ack0, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_rvalid0", rvalid0, 1'b0);
    chk("mid_m_a", m_a, 32'h0);
    chk("mid_m_we", m_we, 1'b0);
    rst = 1'b0;
    cnt = 0;
    repeat (10) begin @(posedge clk); #1; if (rvalid0 || busy) cnt++; end
    chk("mid_quiet", cnt, 0);
    clear_logs();
    burst(0, 32'd9, 0, 1'b1, 1'b0, 2'd0, 32'd7, 32'd0);
    chk("mid_regrant", log_a.size(), 1);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        req[n]  = ($urandom_range(0, 3) == 0);
        addr[n] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                               : 32'($urandom_range(0, 63));
        len[n]  = 4'($urandom_range(0, 15));
        we[n]   = 1'($urandom_range(0, 1));
        e[n]    = 1'($urandom_range(0, 1));
        s[n]    = 1'($urandom_range(0, 1));
        pos[n]  = 2'($urandom_range(0, 3));
        wdv[n]  = $urandom;
        wds[n]  = $urandom;
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
